// File: rtl/ovl_no_over_underflow.sv
// ovl_no_over_underflow
//   Single-clock assertion checker for counters and indices. It can watch for
//   overflow (a write pointer wrapping past max) or for underflow (a read
//   pointer wrapping past min); the parameter underflow picks which one.
//   When test_expr sits at its limit on one edge, the checker arms. If the
//   value on the next edge is outside the legal window, fire pulses for one
//   cycle.
//
// Parameters
//   width      bit width of test_expr
//   min        lower limit (unsigned)
//   max        upper limit (unsigned), must be greater than min
//   underflow  0 = no-overflow check, 1 = no-underflow check
//
// Ports
//   clock      sampling clock, rising edge
//   reset      asynchronous active-high reset; clears armed and fire
//   enable     check qualifier; the checker neither arms nor fires while low
//   test_expr  monitored value, unsigned
//   fire       registered violation pulse
module ovl_no_over_underflow #(
    parameter int unsigned width     = 1,
    parameter int unsigned min       = 0,
    parameter int unsigned max       = (1 << width) - 1,
    parameter bit          underflow = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] test_expr,
    output logic             fire
);

    localparam logic [width-1:0] MIN_V = min[width-1:0];
    localparam logic [width-1:0] MAX_V = max[width-1:0];
    localparam logic [width-1:0] ALL_ONES = {width{1'b1}};

    // The checker arms when test_expr equals the limit at the wrapping edge
    // of the window: max for overflow, min for underflow.
    localparam logic [width-1:0] LIMIT_V = underflow ? MIN_V : MAX_V;

    localparam bit MIN_IS_ZERO = (MIN_V == '0);
    localparam bit MAX_IS_TOP  = (MAX_V == ALL_ONES);

    generate
        if (min >= max) begin : g_bad_limits
            $error("ovl_no_over_underflow: min must be less than max");
        end
    endgenerate

    logic armed_q, armed_d;
    logic fire_q, fire_d;
    logic low_hit;
    logic high_hit;
    logic violation;

    // Each window-edge comparison is folded to a cheaper form when its limit
    // sits at the end of the unsigned range. A compare against zero or all-ones
    // is then either trivially constant or reduces to an equality test.
    generate
        if (underflow) begin : g_under
            // Illegal window for underflow: test_expr < min or test_expr >= max.
            if (MIN_IS_ZERO) begin : g_low
                assign low_hit = 1'b0;
            end else begin : g_low
                assign low_hit = (test_expr < MIN_V);
            end
            if (MAX_IS_TOP) begin : g_high
                assign high_hit = (test_expr == ALL_ONES);
            end else begin : g_high
                assign high_hit = (test_expr >= MAX_V);
            end
        end else begin : g_over
            // Illegal window for overflow: test_expr <= min or test_expr > max.
            if (MIN_IS_ZERO) begin : g_low
                assign low_hit = (test_expr == '0);
            end else begin : g_low
                assign low_hit = (test_expr <= MIN_V);
            end
            if (MAX_IS_TOP) begin : g_high
                assign high_hit = 1'b0;
            end else begin : g_high
                assign high_hit = (test_expr > MAX_V);
            end
        end
    endgenerate

    assign violation = low_hit | high_hit;

    always_comb begin
        armed_d = 1'b0;
        fire_d  = 1'b0;
        if (enable) begin
            armed_d = (test_expr == LIMIT_V);
            fire_d  = armed_q & violation;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            fire_q  <= fire_d;
        end
    end

    assign fire = fire_q;

endmodule

// File: tb/tb_ovl_no_over_underflow.sv
module tb_ovl_no_over_underflow;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] te_ov;
    logic [5:0] te_un;
    logic [4:0] te_pc;
    logic       fire_ov;
    logic       fire_un;
    logic       fire_pc;

    int pass_cnt;
    int total_cnt;

    ovl_no_over_underflow #(.width(6), .min(0), .max(63), .underflow(1'b0)) u_ov (
        .clock(clk), .reset(rst), .enable(en), .test_expr(te_ov), .fire(fire_ov)
    );

    ovl_no_over_underflow #(.width(6), .min(0), .max(63), .underflow(1'b1)) u_un (
        .clock(clk), .reset(rst), .enable(en), .test_expr(te_un), .fire(fire_un)
    );

    ovl_no_over_underflow #(.width(5), .min(10), .max(20), .underflow(1'b0)) u_pc (
        .clock(clk), .reset(rst), .enable(en), .test_expr(te_pc), .fire(fire_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for one rising edge, then move 1 ns past it so outputs are settled.
    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; te_ov = 6'd63; te_un = 6'd0; te_pc = 5'd20;
        edge_tick();
        edge_tick();
        total_cnt++;
        if ({fire_ov, fire_un, fire_pc} !== 3'b000)
            $display("FAIL reset_fire: got %b want 000", {fire_ov, fire_un, fire_pc});
        else pass_cnt++;
        // Armed is held clear during reset, so no check happens on the first edge after release.
        rst = 1'b0; te_ov = 6'd0; te_un = 6'd63; te_pc = 5'd10;
        edge_tick();
        total_cnt++;
        if ({fire_ov, fire_un, fire_pc} !== 3'b000)
            $display("FAIL reset_release_no_check: got %b want 000", {fire_ov, fire_un, fire_pc});
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        te_ov = 6'd62; edge_tick();
        te_ov = 6'd63; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL ov_arm_no_fire: got %b want 0", fire_ov);
        else pass_cnt++;
        te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b1) $display("FAIL ov_wrap_fire: got %b want 1", fire_ov);
        else pass_cnt++;
        te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL ov_pulse_width: got %b want 0", fire_ov);
        else pass_cnt++;
        // Repeated limit value: stays armed, never fires.
        te_ov = 6'd62; edge_tick();
        te_ov = 6'd63; edge_tick();
        te_ov = 6'd63; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL ov_repeat_max: got %b want 0", fire_ov);
        else pass_cnt++;
        te_ov = 6'd5; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL ov_legal_after_max: got %b want 0", fire_ov);
        else pass_cnt++;
        te_ov = 6'd63; edge_tick();
        te_ov = 6'd0;  edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b1) $display("FAIL ov_63_then_0: got %b want 1", fire_ov);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        te_un = 6'd1; edge_tick();
        te_un = 6'd0; edge_tick();
        te_un = 6'd63; edge_tick();
        total_cnt++;
        if (fire_un !== 1'b1) $display("FAIL un_wrap_fire: got %b want 1", fire_un);
        else pass_cnt++;
        te_un = 6'd63; edge_tick();
        total_cnt++;
        if (fire_un !== 1'b0) $display("FAIL un_pulse_width: got %b want 0", fire_un);
        else pass_cnt++;
        te_un = 6'd1; edge_tick();
        te_un = 6'd0; edge_tick();
        te_un = 6'd0; edge_tick();
        total_cnt++;
        if (fire_un !== 1'b0) $display("FAIL un_repeat_min: got %b want 0", fire_un);
        else pass_cnt++;
        te_un = 6'd1; edge_tick();
        total_cnt++;
        if (fire_un !== 1'b0) $display("FAIL un_legal_after_min: got %b want 0", fire_un);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        te_ov = 6'd10; edge_tick();
        en = 1'b1; te_ov = 6'd63; edge_tick();
        en = 1'b0; te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL en_low_skips_check: got %b want 0", fire_ov);
        else pass_cnt++;
        en = 1'b1; te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL en_low_clears_armed: got %b want 0", fire_ov);
        else pass_cnt++;
        // A limit sampled while enable is low must not arm the checker.
        en = 1'b0; te_ov = 6'd63; edge_tick();
        en = 1'b1; te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL en_low_no_arm: got %b want 0", fire_ov);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        te_ov = 6'd63; edge_tick();
        te_ov = 6'd0;  edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b1) $display("FAIL rst_pre_fire: got %b want 1", fire_ov);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL rst_async_clear: got %b want 0", fire_ov);
        else pass_cnt++;
        #1 rst = 1'b0;
        te_ov = 6'd63; edge_tick();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        te_ov = 6'd0; edge_tick();
        total_cnt++;
        if (fire_ov !== 1'b0) $display("FAIL rst_drops_armed: got %b want 0", fire_ov);
        else pass_cnt++;
    endtask

    task automatic test_param_window();
        te_pc = 5'd20; edge_tick();
        te_pc = 5'd10; edge_tick();
        total_cnt++;
        if (fire_pc !== 1'b1) $display("FAIL pc_at_min_fire: got %b want 1", fire_pc);
        else pass_cnt++;
        te_pc = 5'd20; edge_tick();
        te_pc = 5'd21; edge_tick();
        total_cnt++;
        if (fire_pc !== 1'b1) $display("FAIL pc_above_max_fire: got %b want 1", fire_pc);
        else pass_cnt++;
        te_pc = 5'd20; edge_tick();
        te_pc = 5'd15; edge_tick();
        total_cnt++;
        if (fire_pc !== 1'b0) $display("FAIL pc_inside_no_fire: got %b want 0", fire_pc);
        else pass_cnt++;
        te_pc = 5'd20; edge_tick();
        te_pc = 5'd11; edge_tick();
        total_cnt++;
        if (fire_pc !== 1'b0) $display("FAIL pc_min_plus1_no_fire: got %b want 0", fire_pc);
        else pass_cnt++;
        // Out-of-window value without a preceding limit is not checked.
        te_pc = 5'd15; edge_tick();
        te_pc = 5'd25; edge_tick();
        total_cnt++;
        if (fire_pc !== 1'b0) $display("FAIL pc_unarmed_no_fire: got %b want 0", fire_pc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1; en = 1'b0; te_ov = '0; te_un = '0; te_pc = '0;
        test_reset();
        test_overflow();
        test_underflow();
        test_enable();
        test_async_reset();
        test_param_window();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
